// File: rtl/apb_pkg.sv
// Shared state encoding and default widths for the APB round-robin master.
package apb_pkg;

    localparam int unsigned APB_AW = 32;
    localparam int unsigned APB_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after last_grant, with wrap-around.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    int unsigned j;
    logic        found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        if (en) begin
            // Scan starts one past the previous winner so it gets lowest priority next time.
            for (int unsigned k = 1; k <= NREQ; k++) begin
                j = (int'(last_grant) + k) % NREQ;
                if (req[j] && !found) begin
                    found = 1'b1;
                    idx   = IW'(j);
                end
            end
            if (found) begin
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_rr_master_arbiter.sv
// Shares a single APB master port among NREQ requesters with round-robin arbitration
// and an optional wait-state timeout.
module apb_rr_master_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned AW      = APB_AW,
    parameter int unsigned DW      = APB_DW,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [AW-1:0]     PADDR,
    output logic              PWRITE,
    output logic [DW-1:0]     PWDATA,
    input  logic [DW-1:0]     PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    apb_state_e      state_q, state_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic            pwrite_q, pwrite_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req        (req_valid),
        .en         (state_q == IDLE),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .idx        (arb_idx)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        paddr_d      = paddr_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (|arb_grant) begin
                    paddr_d      = req_addr[arb_idx*AW +: AW];
                    pwdata_d     = req_wdata[arb_idx*DW +: DW];
                    pwrite_d     = req_write[arb_idx];
                    last_grant_d = arb_idx;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                cnt_d = cnt_q + CW'(1);
                // A ready slave always beats a coincident timeout.
                if (PREADY) begin
                    rdata_d = pwrite_q ? '0 : PRDATA;
                    err_d   = PSLVERR;
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(NREQ - 1);
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            paddr_q      <= paddr_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        PSEL      = (state_q == SETUP) || (state_q == ACCESS);
        PENABLE   = (state_q == ACCESS);
        PADDR     = paddr_q;
        PWRITE    = pwrite_q;
        PWDATA    = pwdata_q;
        req_ready = arb_grant;
        rsp_valid = (state_q == RESP) ? (NREQ'(1) << last_grant_q) : '0;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Randomized and directed bench for apb_rr_master_arbiter against a transaction-level model.
module tb_apb_rr_master_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned TIMEOUT = 16;

    localparam int PH_IDLE   = 0;
    localparam int PH_SETUP  = 1;
    localparam int PH_ACCESS = 2;
    localparam int PH_RESP   = 3;

    logic                PCLK;
    logic                PRESET;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_write;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_wdata;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [DW-1:0]       rsp_rdata;
    logic                rsp_err;
    logic                PSEL;
    logic                PENABLE;
    logic [AW-1:0]       PADDR;
    logic                PWRITE;
    logic [DW-1:0]       PWDATA;
    logic [DW-1:0]       PRDATA;
    logic                PREADY;
    logic                PSLVERR;

    apb_rr_master_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Requester-side stimulus state
    logic [NREQ-1:0] pend;
    logic            r_write [NREQ];
    logic [AW-1:0]   r_addr  [NREQ];
    logic [DW-1:0]   r_wdata [NREQ];
    bit              rand_req;
    bit              refill;
    int              ready_mode;   // 0 random, 1 always, 2 never, 3 after ready_delay waits
    int              ready_delay;
    bit              fixed_rdata_en;
    logic [DW-1:0]   fixed_rdata;
    int              err_mode;     // 0 random, 1 always 0, 2 always 1

    // Reference model: which bus phase the current transfer is in and what it must show
    int              m_last;
    int              m_phase;
    int              m_win;
    int              m_acc;
    logic            m_write;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [DW-1:0]   m_rdata;
    logic            m_err;

    // Observations of the DUT used by directed checks
    int              grant_log[$];
    int              cyc;
    int              acc_cnt, psel_cnt, last_acc, last_psel;
    int              accept_cyc, rsp_cyc;
    bit              got_rsp;
    logic [DW-1:0]   last_rdata;
    logic            last_err;
    logic [NREQ-1:0] last_rsp_valid;

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= int'(NREQ); k++) begin
            int j = (last + k) % int'(NREQ);
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        pend[i]    = 1'b1;
        r_write[i] = w;
        r_addr[i]  = a;
        r_wdata[i] = d;
    endtask

    task automatic set_rand(input int i);
        set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    task automatic model_reset();
        m_last   = int'(NREQ) - 1;
        m_phase  = PH_IDLE;
        m_acc    = 0;
        m_win    = 0;
        m_write  = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        acc_cnt  = 0;
        psel_cnt = 0;
    endtask

    // Caller may already have raised PRESET asynchronously.
    task automatic apply_reset(input bit clear_pend);
        PRESET = 1'b1;
        #1;
        check_eq("rst_psel", PSEL, 1'b0);
        check_eq("rst_penable", PENABLE, 1'b0);
        check_eq("rst_rsp_valid", rsp_valid, '0);
        check_eq("rst_paddr", PADDR, '0);
        check_eq("rst_pwdata", PWDATA, '0);
        check_eq("rst_pwrite", PWRITE, 1'b0);
        check_eq("rst_rsp_rdata", rsp_rdata, '0);
        check_eq("rst_rsp_err", rsp_err, 1'b0);
        if (clear_pend) pend = '0;
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        model_reset();
    endtask

    task automatic cycle();
        int              win;
        logic [NREQ-1:0] exp_ready;
        logic [NREQ-1:0] exp_rsp;
        @(negedge PCLK);
        cyc++;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (rand_req) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) set_rand(i);
                else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
            end
            if (refill && !pend[i]) set_rand(i);
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            req_valid[i]            = pend[i];
            req_write[i]            = r_write[i];
            req_addr[i*AW +: AW]    = r_addr[i];
            req_wdata[i*DW +: DW]   = r_wdata[i];
        end
        PRDATA  = fixed_rdata_en ? fixed_rdata : DW'($urandom);
        PSLVERR = (err_mode == 0) ? 1'($urandom_range(0, 1)) : (err_mode == 2);
        case (ready_mode)
            0:       PREADY = ($urandom_range(0, 2) == 0);
            1:       PREADY = 1'b1;
            2:       PREADY = 1'b0;
            default: PREADY = (m_phase == PH_ACCESS) && (m_acc == ready_delay);
        endcase
        #1;
        exp_ready = '0;
        exp_rsp   = '0;
        win       = -1;
        if (m_phase == PH_IDLE) begin
            win = rr_pick(pend, m_last);
            if (win >= 0) exp_ready[win] = 1'b1;
        end
        if (m_phase == PH_RESP) exp_rsp[m_win] = 1'b1;
        check_eq("psel", PSEL, (m_phase == PH_SETUP) || (m_phase == PH_ACCESS));
        check_eq("penable", PENABLE, m_phase == PH_ACCESS);
        check_eq("req_ready", req_ready, exp_ready);
        check_eq("rsp_valid", rsp_valid, exp_rsp);
        check_eq("paddr", PADDR, m_addr);
        check_eq("pwrite", PWRITE, m_write);
        check_eq("pwdata", PWDATA, m_wdata);
        if (m_phase == PH_RESP) begin
            check_eq("rsp_rdata", rsp_rdata, m_rdata);
            check_eq("rsp_err", rsp_err, m_err);
        end
        if (PSEL) psel_cnt++;
        if (PENABLE) acc_cnt++;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (req_ready[i]) begin
                grant_log.push_back(i);
                accept_cyc = cyc;
            end
        end
        if (|rsp_valid) begin
            got_rsp        = 1'b1;
            rsp_cyc        = cyc;
            last_acc       = acc_cnt;
            last_psel      = psel_cnt;
            last_rdata     = rsp_rdata;
            last_err       = rsp_err;
            last_rsp_valid = rsp_valid;
            acc_cnt        = 0;
            psel_cnt       = 0;
        end
        case (m_phase)
            PH_IDLE: begin
                if (win >= 0) begin
                    m_win   = win;
                    m_last  = win;
                    m_write = r_write[win];
                    m_addr  = r_addr[win];
                    m_wdata = r_wdata[win];
                    pend[win] = 1'b0;
                    m_phase = PH_SETUP;
                end
            end
            PH_SETUP: begin
                m_acc   = 0;
                m_phase = PH_ACCESS;
            end
            PH_ACCESS: begin
                if (PREADY) begin
                    m_rdata = m_write ? '0 : PRDATA;
                    m_err   = PSLVERR;
                    m_phase = PH_RESP;
                end else if (TIMEOUT != 0 && m_acc == int'(TIMEOUT) - 1) begin
                    m_rdata = '0;
                    m_err   = 1'b1;
                    m_phase = PH_RESP;
                end else begin
                    m_acc++;
                end
            end
            default: m_phase = PH_IDLE;
        endcase
    endtask

    task automatic run_until_resp(input int budget);
        got_rsp = 1'b0;
        for (int c = 0; c < budget && !got_rsp; c++) cycle();
        check_eq("rsp_budget", got_rsp, 1'b1);
    endtask

    task automatic directed_setup();
        rand_req       = 1'b0;
        refill         = 1'b0;
        fixed_rdata_en = 1'b0;
        err_mode       = 1;
        apply_reset(1'b1);
    endtask

    initial begin
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        PRESET      = 1'b1;
        pend        = '0;
        req_valid   = '0;
        req_write   = '0;
        req_addr    = '0;
        req_wdata   = '0;
        PRDATA      = '0;
        PREADY      = 1'b0;
        PSLVERR     = 1'b0;
        ready_mode  = 1;
        ready_delay = 0;
        fixed_rdata = '0;
        cyc         = 0;
        for (int i = 0; i < int'(NREQ); i++) begin
            r_write[i] = 1'b0;
            r_addr[i]  = '0;
            r_wdata[i] = '0;
        end
        #12;

        // Single read from requester 2
        directed_setup();
        ready_mode     = 1;
        fixed_rdata_en = 1'b1;
        fixed_rdata    = 32'hDEADBEEF;
        set_req(2, 1'b0, 32'h40, 32'h0);
        run_until_resp(20);
        check_eq("t1_rdata", last_rdata, 32'hDEADBEEF);
        check_eq("t1_err", last_err, 1'b0);
        check_eq("t1_rsp_valid", last_rsp_valid, 4'b0100);
        check_eq("t1_psel_cycles", last_psel, 2);
        check_eq("t1_penable_cycles", last_acc, 1);
        check_eq("t1_latency", rsp_cyc - accept_cyc, 3);

        // All requesters continuously valid
        directed_setup();
        refill = 1'b1;
        grant_log.delete();
        for (int c = 0; c < 40 && grant_log.size() < 5; c++) cycle();
        check_eq("t2_ngrants", grant_log.size() >= 5, 1'b1);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            check_eq($sformatf("t2_order%0d", k), grant_log[k], exp_order[k]);

        // Write with three wait states and a slave error
        directed_setup();
        ready_mode  = 3;
        ready_delay = 3;
        err_mode    = 2;
        set_req(0, 1'b1, 32'h10, 32'h12345678);
        run_until_resp(30);
        check_eq("t3_err", last_err, 1'b1);
        check_eq("t3_rdata", last_rdata, '0);
        check_eq("t3_psel_cycles", last_psel, 5);
        check_eq("t3_penable_cycles", last_acc, 4);

        // Slave never ready: timeout
        directed_setup();
        ready_mode = 2;
        set_req(1, 1'b0, 32'h80, 32'h0);
        run_until_resp(40);
        check_eq("t4_access_cycles", last_acc, int'(TIMEOUT));
        check_eq("t4_err", last_err, 1'b1);
        check_eq("t4_rdata", last_rdata, '0);
        cycle();
        check_eq("t4_bus_idle", PSEL, 1'b0);

        // Ready coincides with the timeout limit
        directed_setup();
        ready_mode     = 3;
        ready_delay    = int'(TIMEOUT) - 1;
        fixed_rdata_en = 1'b1;
        fixed_rdata    = 32'hCAFEF00D;
        set_req(3, 1'b0, 32'hC0, 32'h0);
        run_until_resp(40);
        check_eq("t5_access_cycles", last_acc, int'(TIMEOUT));
        check_eq("t5_err", last_err, 1'b0);
        check_eq("t5_rdata", last_rdata, 32'hCAFEF00D);

        // Reset while in ACCESS
        directed_setup();
        ready_mode = 2;
        set_req(3, 1'b0, 32'h44, 32'h0);
        for (int c = 0; c < 4; c++) cycle();
        check_eq("t6_in_access", PENABLE, 1'b1);
        @(negedge PCLK);
        #2;
        PRESET = 1'b1;
        apply_reset(1'b1);
        for (int i = 0; i < int'(NREQ); i++) set_rand(i);
        grant_log.delete();
        cycle();
        check_eq("t6_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        ready_mode = 1;
        run_until_resp(20);

        // Random traffic
        rand_req       = 1'b1;
        refill         = 1'b0;
        ready_mode     = 0;
        fixed_rdata_en = 1'b0;
        err_mode       = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 400) ready_mode = 2;
            if (c % 500 == 430) ready_mode = 0;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
